// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the RV64 ALU: decodes RV64I integer-compute instructions
// into operands and an op select, and holds them in one valid/ready pipeline register.
module alu_issue_stage #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0]  pc,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [DATA_WIDTH-1:0]  rs1_data,
  input  logic [DATA_WIDTH-1:0]  rs2_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [4:0]             alu_sel,
  output logic [4:0]             rd,
  output logic                   reg_write,
  output logic                   illegal
);

  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SUB  = 5'd1;
  localparam logic [4:0] SEL_AND  = 5'd2;
  localparam logic [4:0] SEL_OR   = 5'd3;
  localparam logic [4:0] SEL_XOR  = 5'd4;
  localparam logic [4:0] SEL_SLT  = 5'd5;
  localparam logic [4:0] SEL_SLTU = 5'd6;
  localparam logic [4:0] SEL_SLL  = 5'd7;
  localparam logic [4:0] SEL_SRL  = 5'd8;
  localparam logic [4:0] SEL_SRA  = 5'd9;
  localparam logic [4:0] SEL_ADDW = 5'd10;
  localparam logic [4:0] SEL_SUBW = 5'd11;
  localparam logic [4:0] SEL_SLLW = 5'd12;
  localparam logic [4:0] SEL_SRLW = 5'd13;
  localparam logic [4:0] SEL_SRAW = 5'd14;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  f7_zero;
  logic                  f7_alt;
  logic                  sh6_zero;
  logic                  sh6_alt;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt6;
  logic [DATA_WIDTH-1:0] shamt5;
  logic [DATA_WIDTH-1:0] raw_a;
  logic [DATA_WIDTH-1:0] raw_b;
  logic [4:0]            raw_sel;
  logic                  dec_legal;
  logic                  transfer;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign f7_zero  = (instr[31:25] == 7'b0000000);
  assign f7_alt   = (instr[31:25] == 7'b0100000);
  assign sh6_zero = (instr[31:26] == 6'b000000);
  assign sh6_alt  = (instr[31:26] == 6'b010000);
  assign imm_i    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_u    = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
  assign shamt6   = {{(DATA_WIDTH-6){1'b0}}, instr[25:20]};
  assign shamt5   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  always_comb begin
    raw_a     = '0;
    raw_b     = '0;
    raw_sel   = SEL_ADD;
    dec_legal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: begin
          raw_a = rs1_data;
          raw_b = rs2_data;
          case (funct3)
            3'b000: begin dec_legal = f7_zero || f7_alt; raw_sel = f7_alt ? SEL_SUB : SEL_ADD; end
            3'b001: begin dec_legal = f7_zero; raw_sel = SEL_SLL;  end
            3'b010: begin dec_legal = f7_zero; raw_sel = SEL_SLT;  end
            3'b011: begin dec_legal = f7_zero; raw_sel = SEL_SLTU; end
            3'b100: begin dec_legal = f7_zero; raw_sel = SEL_XOR;  end
            3'b101: begin dec_legal = f7_zero || f7_alt; raw_sel = f7_alt ? SEL_SRA : SEL_SRL; end
            3'b110: begin dec_legal = f7_zero; raw_sel = SEL_OR;   end
            default: begin dec_legal = f7_zero; raw_sel = SEL_AND; end
          endcase
        end
        OPC_OP_IMM: begin
          raw_a = rs1_data;
          raw_b = imm_i;
          case (funct3)
            3'b000: begin dec_legal = 1'b1; raw_sel = SEL_ADD;  end
            3'b001: begin dec_legal = sh6_zero; raw_sel = SEL_SLL; raw_b = shamt6; end
            3'b010: begin dec_legal = 1'b1; raw_sel = SEL_SLT;  end
            3'b011: begin dec_legal = 1'b1; raw_sel = SEL_SLTU; end
            3'b100: begin dec_legal = 1'b1; raw_sel = SEL_XOR;  end
            3'b101: begin
              dec_legal = sh6_zero || sh6_alt;
              raw_sel   = sh6_alt ? SEL_SRA : SEL_SRL;
              raw_b     = shamt6;
            end
            3'b110: begin dec_legal = 1'b1; raw_sel = SEL_OR;   end
            default: begin dec_legal = 1'b1; raw_sel = SEL_AND; end
          endcase
        end
        OPC_OP_32: begin
          raw_a = rs1_data;
          raw_b = rs2_data;
          case (funct3)
            3'b000: begin dec_legal = f7_zero || f7_alt; raw_sel = f7_alt ? SEL_SUBW : SEL_ADDW; end
            3'b001: begin dec_legal = f7_zero; raw_sel = SEL_SLLW; end
            3'b101: begin dec_legal = f7_zero || f7_alt; raw_sel = f7_alt ? SEL_SRAW : SEL_SRLW; end
            default: dec_legal = 1'b0;
          endcase
        end
        OPC_OP_IMM32: begin
          raw_a = rs1_data;
          case (funct3)
            3'b000: begin dec_legal = 1'b1; raw_sel = SEL_ADDW; raw_b = imm_i; end
            3'b001: begin dec_legal = f7_zero; raw_sel = SEL_SLLW; raw_b = shamt5; end
            3'b101: begin
              dec_legal = f7_zero || f7_alt;
              raw_sel   = f7_alt ? SEL_SRAW : SEL_SRLW;
              raw_b     = shamt5;
            end
            default: dec_legal = 1'b0;
          endcase
        end
        OPC_LUI: begin
          dec_legal = 1'b1;
          raw_b     = imm_u;
        end
        OPC_AUIPC: begin
          dec_legal = 1'b1;
          raw_a     = pc;
          raw_b     = imm_u;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  // Illegal instructions still travel downstream, but with zeroed operands and no write.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= SEL_ADD;
      rd        <= '0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      alu_a     <= dec_legal ? raw_a : '0;
      alu_b     <= dec_legal ? raw_b : '0;
      alu_sel   <= dec_legal ? raw_sel : SEL_ADD;
      rd        <= instr[11:7];
      reg_write <= dec_legal && (instr[11:7] != 5'd0);
      illegal   <= !dec_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage: decode vectors with hand-computed
// results, plus hand-written backpressure, flush and reset sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_sel;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [4:0]  exp_sel;
    logic [4:0]  exp_rd;
    logic        exp_rw;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  alu_issue_stage #(.DATA_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .rd        (rd),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [63:0] ea, input logic [63:0] eb,
                         input logic [4:0] es, input logic [4:0] erd, input logic erw,
                         input logic eill);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.exp_a = ea; v.exp_b = eb; v.exp_sel = es; v.exp_rd = erd;
    v.exp_rw = erw; v.exp_ill = eill;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    in_valid = 1'b1;
    instr    = v.instr;
    pc       = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
  endtask

  task automatic check_val(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input logic ev, input vec_t v);
    vectors_applied++;
    if (out_valid !== ev || alu_a !== v.exp_a || alu_b !== v.exp_b || alu_sel !== v.exp_sel ||
        rd !== v.exp_rd || reg_write !== v.exp_rw || illegal !== v.exp_ill) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%0b a=0x%0h b=0x%0h sel=%0d rd=%0d we=%0b ill=%0b, expected v=%0b a=0x%0h b=0x%0h sel=%0d rd=%0d we=%0b ill=%0b",
               name, out_valid, alu_a, alu_b, alu_sel, rd, reg_write, illegal,
               ev, v.exp_a, v.exp_b, v.exp_sel, v.exp_rd, v.exp_rw, v.exp_ill);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t zero_v;
    vec_t va;
    vec_t vb;
    logic [63:0] r1;
    logic [63:0] r2;
    r1 = 64'h1111_2222_3333_4444;
    r2 = 64'h0F0F_0000_FFFF_1234;

    // instr, pc, rs1, rs2, a, b, sel, rd, reg_write, illegal
    add_vec(32'h002081B3, 64'h0, 64'd5, 64'd7, 64'd5, 64'd7, 5'd0, 5'd3, 1'b1, 1'b0);
    add_vec(32'h41F3D31B, 64'h0, 64'h8000_0000, r2, 64'h8000_0000, 64'd31, 5'd14, 5'd6, 1'b1, 1'b0);
    add_vec(32'h43F3D31B, 64'h0, 64'h8000_0000, r2, 64'h0, 64'h0, 5'd0, 5'd6, 1'b0, 1'b1);
    add_vec(32'hFFF00293, 64'h0, 64'h0, r2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd5, 1'b1, 1'b0);
    add_vec(32'h123450B7, 64'h0, r1, r2, 64'h0, 64'h0000_0000_1234_5000, 5'd0, 5'd1, 1'b1, 1'b0);
    add_vec(32'h80000097, 64'h1000, r1, r2, 64'h1000, 64'hFFFF_FFFF_8000_0000, 5'd0, 5'd1, 1'b1, 1'b0);
    add_vec(32'h00000013, 64'h0, 64'h0, r2, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    add_vec(32'h40C58533, 64'h0, 64'd100, 64'd30, 64'd100, 64'd30, 5'd1, 5'd10, 1'b1, 1'b0);
    add_vec(32'h403150B3, 64'h0, r1, r2, r1, r2, 5'd9, 5'd1, 1'b1, 1'b0);
    add_vec(32'h403160B3, 64'h0, r1, r2, 64'h0, 64'h0, 5'd0, 5'd1, 1'b0, 1'b1);
    add_vec(32'h03F19113, 64'h0, r1, r2, r1, 64'd63, 5'd7, 5'd2, 1'b1, 1'b0);
    add_vec(32'h4051D113, 64'h0, r1, r2, r1, 64'd5, 5'd9, 5'd2, 1'b1, 1'b0);
    add_vec(32'hFFE2B213, 64'h0, r1, r2, r1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd6, 5'd4, 1'b1, 1'b0);
    add_vec(32'h003120BB, 64'h0, r1, r2, 64'h0, 64'h0, 5'd0, 5'd1, 1'b0, 1'b1);
    add_vec(32'h403100BB, 64'h0, r1, r2, r1, r2, 5'd11, 5'd1, 1'b1, 1'b0);
    add_vec(32'h01F1109B, 64'h0, r1, r2, r1, 64'd31, 5'd12, 5'd1, 1'b1, 1'b0);
    add_vec(32'h002081B0, 64'h0, r1, r2, 64'h0, 64'h0, 5'd0, 5'd3, 1'b0, 1'b1);
    add_vec(32'h00000063, 64'h0, r1, r2, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    add_vec(32'h009443B3, 64'h0, r1, r2, r1, r2, 5'd4, 5'd7, 1'b1, 1'b0);

    zero_v = '{default: '0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 64'h0;
    rs1_data  = 64'h0;
    rs2_data  = 64'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check_output("reset_state", 1'b0, zero_v);
    rst = 1'b0;

    // Back-to-back decode vectors with the consumer always ready.
    check_val("rs_addr_add", {49'b0, rs1_addr, 5'b0, rs2_addr}, 64'h0);
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      #1;
      if (i == 0) begin
        check_val("rs1_addr", {59'b0, rs1_addr}, 64'd1);
        check_val("rs2_addr", {59'b0, rs2_addr}, 64'd2);
      end
      step();
      check_output($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end
    in_valid = 1'b0;
    step();
    check_val("drain_out_valid", {63'b0, out_valid}, 64'd0);

    // Backpressure: hold A for three cycles while B waits, then B exactly once.
    va = vecs[0];
    vb = vecs[4];
    apply_stimulus(va);
    step();
    check_output("bp_load_a", 1'b1, va);
    out_ready = 1'b0;
    apply_stimulus(vb);
    for (int c = 0; c < 3; c++) begin
      step();
      check_val($sformatf("bp_in_ready_%0d", c), {63'b0, in_ready}, 64'd0);
      check_output($sformatf("bp_hold_a_%0d", c), 1'b1, va);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_in_ready_release", {63'b0, in_ready}, 64'd1);
    step();
    check_output("bp_load_b", 1'b1, vb);
    in_valid = 1'b0;
    step();
    check_val("bp_no_dup", {63'b0, out_valid}, 64'd0);

    // Flush while a result is pending and a new instruction is offered.
    apply_stimulus(va);
    step();
    check_output("fl_load_a", 1'b1, va);
    out_ready = 1'b0;
    flush     = 1'b1;
    apply_stimulus(vb);
    #1;
    check_val("fl_in_ready", {63'b0, in_ready}, 64'd0);
    step();
    check_val("fl_out_valid", {63'b0, out_valid}, 64'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("fl_dropped", {63'b0, out_valid}, 64'd0);

    // Reset mid-stream with an instruction being offered.
    apply_stimulus(va);
    step();
    check_output("rs_load_a", 1'b1, va);
    apply_stimulus(vb);
    rst = 1'b1;
    step();
    check_output("rs_cleared", 1'b0, zero_v);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check_val("rs_stays_idle", {63'b0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
